// File: rtl/ysyx_22040125_pipe_pkg.sv
// Shared types for the ysyx_22040125 pipeline stage registers: occupancy
// states and the packed bundles carried across each stage boundary.
package ysyx_22040125_pipe_pkg;

  // Occupancy encoding is {S.valid, M.valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } pipe_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [15:0] ctrl;
  } id_exe_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] alu_res;
    logic [63:0] store_val;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } exe_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] wb_val;
    logic [4:0]  rd;
    logic        wen;
  } mem_wb_t;

  localparam int unsigned IF_ID_W   = $bits(if_id_t);
  localparam int unsigned ID_EXE_W  = $bits(id_exe_t);
  localparam int unsigned EXE_MEM_W = $bits(exe_mem_t);
  localparam int unsigned MEM_WB_W  = $bits(mem_wb_t);

endpackage

// File: rtl/ysyx_22040125_pipe_slot.sv
// One storage entry of a pipe stage: valid bit plus payload register.
module ysyx_22040125_pipe_slot #(
  parameter int unsigned      WIDTH   = 64,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Valid bit: clear has priority, load marks the entry occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid <= 1'b0;
    else if (clear) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
  end

  // Payload only changes on load, so idle in_data never propagates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       data <= RST_VAL;
    else if (load) data <= d;
  end

endmodule

// File: rtl/ysyx_22040125_pipe_stage.sv
// Handshaked pipeline stage register with optional two-entry skid buffer.
// M is the oldest entry and drives out_data; S catches the one extra beat
// that arrives after back-pressure so in_ready stays registered.
module ysyx_22040125_pipe_stage
  import ysyx_22040125_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 64,
  parameter bit               SKID    = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic             m_valid, s_valid;
  logic [WIDTH-1:0] m_data, s_data, m_d;
  logic             m_load, m_clear, s_load, s_clear, m_from_s;
  logic             accept, deliver;
  pipe_state_e      state;

  assign state     = pipe_state_e'({s_valid, m_valid});
  assign out_valid = m_valid & ~flush;
  assign out_data  = m_data;
  assign count     = {1'b0, m_valid} + {1'b0, s_valid};

  // Ready: registered-only with skid, pass-through of out_ready without.
  always_comb begin
    if (SKID) in_ready = ~s_valid & ~flush;
    else      in_ready = (~m_valid | out_ready) & ~flush;
  end

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  // Slot load/clear decode from occupancy and this cycle's handshakes.
  always_comb begin
    m_load   = 1'b0;
    m_clear  = 1'b0;
    s_load   = 1'b0;
    s_clear  = 1'b0;
    m_from_s = 1'b0;
    case (state)
      ONE: begin
        if (deliver && accept) m_load  = 1'b1;
        else if (deliver)      m_clear = 1'b1;
        else if (accept)       s_load  = 1'b1;
      end
      FULL: begin
        if (deliver) begin
          m_load   = 1'b1;
          m_from_s = 1'b1;
          s_clear  = 1'b1;
        end
      end
      default: m_load = accept;
    endcase
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end
  end

  assign m_d = m_from_s ? s_data : in_data;

  ysyx_22040125_pipe_slot #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_m (
    .clk(clk), .rst(rst), .load(m_load), .clear(m_clear),
    .d(m_d), .valid(m_valid), .data(m_data)
  );

  generate
    if (SKID) begin : g_skid
      ysyx_22040125_pipe_slot #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_s (
        .clk(clk), .rst(rst), .load(s_load), .clear(s_clear),
        .d(in_data), .valid(s_valid), .data(s_data)
      );
    end else begin : g_noskid
      assign s_valid = 1'b0;
      assign s_data  = RST_VAL;
    end
  endgenerate

endmodule

// File: tb/tb_ysyx_22040125_pipe_stage.sv
// Directed and randomised checks of the pipe stage in both SKID modes.
module tb_ysyx_22040125_pipe_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;

  logic       flush1 = 0, in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 0;
  logic [7:0] in_data1 = '0, out_data1;
  logic [1:0] count1;
  logic       flush0 = 0, in_valid0 = 0, in_ready0, out_valid0, out_ready0 = 0;
  logic [7:0] in_data0 = '0, out_data0;
  logic [1:0] count0;

  always #5 clk = ~clk;

  ysyx_22040125_pipe_stage #(.WIDTH(8), .SKID(1'b1), .RST_VAL(8'h5A)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .count(count1)
  );

  ysyx_22040125_pipe_stage #(.WIDTH(8), .SKID(1'b0), .RST_VAL(8'h5A)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .count(count0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid1 = 1; out_ready1 = 0; in_data1 = 8'h0A; tick();
    in_data1 = 8'h0B; tick();
    in_valid1 = 0;
    checks++; if (count1 !== 2'd2) begin errors++; $display("FAIL rst_prefill_count got %0d exp 2", count1); end
    #2 rst = 1; #1;
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_out_valid1 got %b exp 0", out_valid1); end
    checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL rst_count1 got %0d exp 0", count1); end
    checks++; if (out_data1 !== 8'h5A) begin errors++; $display("FAIL rst_out_data1 got %h exp 5a", out_data1); end
    checks++; if (count0 !== 2'd0) begin errors++; $display("FAIL rst_count0 got %0d exp 0", count0); end
    checks++; if (out_data0 !== 8'h5A) begin errors++; $display("FAIL rst_out_data0 got %h exp 5a", out_data0); end
    #2 rst = 0; #1;
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL rst_in_ready1 got %b exp 1", in_ready1); end
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL rst_in_ready0 got %b exp 1", in_ready0); end
    tick();
    checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL rst_post_count1 got %0d exp 0", count1); end
  endtask

  task automatic test_stream();
    in_valid1 = 1; out_ready1 = 1; in_valid0 = 1; out_ready0 = 1;
    for (int i = 1; i <= 6; i++) begin
      in_data1 = 8'(i); in_data0 = 8'(i);
      tick();
      checks++; if (out_valid1 !== 1'b1 || out_data1 !== 8'(i) || count1 !== 2'd1) begin
        errors++; $display("FAIL stream_skid1 beat %0d got v=%b d=%h c=%0d exp v=1 d=%h c=1", i, out_valid1, out_data1, count1, 8'(i));
      end
      checks++; if (out_valid0 !== 1'b1 || out_data0 !== 8'(i) || count0 !== 2'd1) begin
        errors++; $display("FAIL stream_skid0 beat %0d got v=%b d=%h c=%0d exp v=1 d=%h c=1", i, out_valid0, out_data0, count0, 8'(i));
      end
    end
    in_valid1 = 0; in_valid0 = 0;
    tick();
    checks++; if (count1 !== 2'd0 || count0 !== 2'd0) begin
      errors++; $display("FAIL stream_drain got c1=%0d c0=%0d exp 0 0", count1, count0);
    end
  endtask

  task automatic test_backpressure();
    in_valid1 = 1; out_ready1 = 1; in_data1 = 8'h10; tick();
    in_data1 = 8'h11; out_ready1 = 0; #1;
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL bp_ready_at_drop got %b exp 1", in_ready1); end
    tick();
    checks++; if (count1 !== 2'd2 || in_ready1 !== 1'b0) begin
      errors++; $display("FAIL bp_full got c=%0d r=%b exp c=2 r=0", count1, in_ready1);
    end
    in_data1 = 8'h12; tick();
    checks++; if (count1 !== 2'd2 || out_data1 !== 8'h10) begin
      errors++; $display("FAIL bp_hold got c=%0d d=%h exp c=2 d=10", count1, out_data1);
    end
    tick();
    out_ready1 = 1; tick();
    checks++; if (out_data1 !== 8'h11 || count1 !== 2'd1 || in_ready1 !== 1'b1) begin
      errors++; $display("FAIL bp_release1 got d=%h c=%0d r=%b exp d=11 c=1 r=1", out_data1, count1, in_ready1);
    end
    tick();
    checks++; if (out_data1 !== 8'h12 || count1 !== 2'd1) begin
      errors++; $display("FAIL bp_release2 got d=%h c=%0d exp d=12 c=1", out_data1, count1);
    end
    in_valid1 = 0; tick();
    checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL bp_drain got c=%0d exp 0", count1); end
  endtask

  task automatic test_flush();
    in_valid1 = 1; out_ready1 = 0; in_data1 = 8'h05; tick();
    in_data1 = 8'h06; tick();
    flush1 = 1; in_data1 = 8'h07; out_ready1 = 1; #1;
    checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b0) begin
      errors++; $display("FAIL flush_same_cycle got v=%b r=%b exp 0 0", out_valid1, in_ready1);
    end
    tick();
    flush1 = 0; in_valid1 = 0; #1;
    checks++; if (out_valid1 !== 1'b0 || count1 !== 2'd0 || out_data1 !== 8'h05) begin
      errors++; $display("FAIL flush_after got v=%b c=%0d d=%h exp v=0 c=0 d=05", out_valid1, count1, out_data1);
    end
    tick();
    checks++; if (count1 !== 2'd0 || out_valid1 !== 1'b0) begin
      errors++; $display("FAIL flush_nothing_left got c=%0d v=%b exp 0 0", count1, out_valid1);
    end
  endtask

  task automatic test_comb_ready();
    in_valid0 = 1; out_ready0 = 0; in_data0 = 8'h21; tick();
    in_data0 = 8'h22; #1;
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL comb_ready_blocked got %b exp 0", in_ready0); end
    tick();
    checks++; if (out_data0 !== 8'h21 || count0 !== 2'd1) begin
      errors++; $display("FAIL comb_hold got d=%h c=%0d exp d=21 c=1", out_data0, count0);
    end
    out_ready0 = 1; #1;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL comb_ready_pass got %b exp 1", in_ready0); end
    tick();
    checks++; if (out_data0 !== 8'h22 || count0 !== 2'd1) begin
      errors++; $display("FAIL comb_replace got d=%h c=%0d exp d=22 c=1", out_data0, count0);
    end
    in_valid0 = 0; tick();
    checks++; if (count0 !== 2'd0) begin errors++; $display("FAIL comb_drain got c=%0d exp 0", count0); end
  endtask

  task automatic test_random();
    logic [7:0] q1[$];
    logic [7:0] q0[$];
    logic       er1, er0, acc1, acc0, del1, del0;
    for (int c = 0; c < 3000; c++) begin
      in_valid1 = 1'($urandom_range(0, 1)); out_ready1 = 1'($urandom_range(0, 1));
      flush1 = ($urandom_range(0, 31) == 0); in_data1 = 8'($urandom);
      in_valid0 = 1'($urandom_range(0, 1)); out_ready0 = 1'($urandom_range(0, 1));
      flush0 = ($urandom_range(0, 31) == 0); in_data0 = 8'($urandom);
      #2;
      er1  = (q1.size() < 2) && !flush1;
      er0  = ((q0.size() == 0) || out_ready0) && !flush0;
      acc1 = in_valid1 && er1;
      acc0 = in_valid0 && er0;
      del1 = (q1.size() > 0) && !flush1 && out_ready1;
      del0 = (q0.size() > 0) && !flush0 && out_ready0;
      checks++; if (in_ready1 !== er1 || out_valid1 !== ((q1.size() > 0) && !flush1)) begin
        errors++; $display("FAIL rnd1_hs cyc %0d got r=%b v=%b exp r=%b v=%b", c, in_ready1, out_valid1, er1, (q1.size() > 0) && !flush1);
      end
      checks++; if (in_ready0 !== er0 || out_valid0 !== ((q0.size() > 0) && !flush0)) begin
        errors++; $display("FAIL rnd0_hs cyc %0d got r=%b v=%b exp r=%b v=%b", c, in_ready0, out_valid0, er0, (q0.size() > 0) && !flush0);
      end
      if (del1) begin
        checks++; if (out_data1 !== q1[0]) begin errors++; $display("FAIL rnd1_data cyc %0d got %h exp %h", c, out_data1, q1[0]); end
        void'(q1.pop_front());
      end
      if (del0) begin
        checks++; if (out_data0 !== q0[0]) begin errors++; $display("FAIL rnd0_data cyc %0d got %h exp %h", c, out_data0, q0[0]); end
        void'(q0.pop_front());
      end
      if (acc1) q1.push_back(in_data1);
      if (acc0) q0.push_back(in_data0);
      if (flush1) q1.delete();
      if (flush0) q0.delete();
      tick();
      checks++; if (count1 !== 2'(q1.size())) begin errors++; $display("FAIL rnd1_count cyc %0d got %0d exp %0d", c, count1, q1.size()); end
      checks++; if (count0 !== 2'(q0.size())) begin errors++; $display("FAIL rnd0_count cyc %0d got %0d exp %0d", c, count0, q0.size()); end
    end
    in_valid1 = 0; in_valid0 = 0; flush1 = 0; flush0 = 0;
  endtask

  initial begin
    #12 rst = 0;
    tick();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_comb_ready();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
